// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - coin codes, coin values and FSM states shared by the vending coin blocks
package vend_pkg;

  localparam logic [1:0] COIN_TEN    = 2'b00;
  localparam logic [1:0] COIN_TWENTY = 2'b01;
  localparam logic [1:0] COIN_FIFTY  = 2'b10;

  // Coin values in units of 10
  localparam logic [2:0] VAL_TEN    = 3'd1;
  localparam logic [2:0] VAL_TWENTY = 3'd2;
  localparam logic [2:0] VAL_FIFTY  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [2:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_FIFTY:  return VAL_FIFTY;
      COIN_TWENTY: return VAL_TWENTY;
      default:     return VAL_TEN;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - per-denomination saturating coin counters with refill and single-coin decrement
module coin_inventory
  import vend_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int INIT_CNT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill_en,
  input  logic [1:0]       refill_coin,
  input  logic [CNT_W-1:0] refill_qty,
  input  logic             dec_en,
  input  logic [1:0]       dec_coin,
  output logic             nz_ten,
  output logic             nz_twenty,
  output logic             nz_fifty
);

  localparam logic [CNT_W-1:0] INIT = CNT_W'(INIT_CNT);

  logic [2:0] w_nz;

  // Index g matches the coin code, so code 2'b11 never selects a counter
  for (genvar g = 0; g < 3; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_sum;

    assign w_sum = {1'b0, r_cnt} + {1'b0, refill_qty};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= INIT;
      end else if (refill_en && refill_coin == 2'(g)) begin
        r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end else if (dec_en && dec_coin == 2'(g) && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end

    assign w_nz[g] = |r_cnt;
  end

  assign nz_ten    = w_nz[COIN_TEN];
  assign nz_twenty = w_nz[COIN_TWENTY];
  assign nz_fifty  = w_nz[COIN_FIFTY];

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 50/20/10 change payout to a valid/ready coin hopper
// Optional: CHG_TIMEOUT_EN adds a jam output and an eject-handshake timeout.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 6,
  parameter int INIT_CNT    = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill_en,
  input  logic [1:0]       refill_coin,
  input  logic [CNT_W-1:0] refill_qty,
  input  logic             eject_ready,
  output logic             eject_valid,
  output logic [1:0]       eject_coin,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining
`ifdef CHG_TIMEOUT_EN
  ,
  output logic             jam
`endif
);

  state_t           r_state;
  logic [1:0]       r_coin;
  logic [AMT_W-1:0] r_rem;
  logic             r_short;

  logic       w_nz_ten;
  logic       w_nz_twenty;
  logic       w_nz_fifty;
  logic       w_xfer;
  logic       w_refill;
  logic       w_sel_ok;
  logic [1:0] w_sel_coin;

  assign w_xfer   = (r_state == ST_EJECT) && eject_ready;
  assign w_refill = (r_state == ST_IDLE) && refill_en;

  coin_inventory #(
    .CNT_W    (CNT_W),
    .INIT_CNT (INIT_CNT)
  ) u_inv (
    .clk         (clk),
    .reset       (reset),
    .refill_en   (w_refill),
    .refill_coin (refill_coin),
    .refill_qty  (refill_qty),
    .dec_en      (w_xfer),
    .dec_coin    (r_coin),
    .nz_ten      (w_nz_ten),
    .nz_twenty   (w_nz_twenty),
    .nz_fifty    (w_nz_fifty)
  );

  // A coin is only offered when it fits in r_rem, so r_rem cannot underflow
  always_comb begin
    w_sel_ok   = 1'b1;
    w_sel_coin = COIN_TEN;
    if (r_rem >= AMT_W'(VAL_FIFTY) && w_nz_fifty) begin
      w_sel_coin = COIN_FIFTY;
    end else if (r_rem >= AMT_W'(VAL_TWENTY) && w_nz_twenty) begin
      w_sel_coin = COIN_TWENTY;
    end else if (w_nz_ten) begin
      w_sel_coin = COIN_TEN;
    end else begin
      w_sel_ok = 1'b0;
    end
  end

`ifdef CHG_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] r_wait;
  logic              r_jam;
  assign jam = r_jam;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_coin  <= COIN_TEN;
      r_rem   <= '0;
      r_short <= 1'b0;
`ifdef CHG_TIMEOUT_EN
      r_wait  <= '0;
      r_jam   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem   <= amount;
            r_short <= 1'b0;
`ifdef CHG_TIMEOUT_EN
            r_jam   <= 1'b0;
`endif
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (r_rem == '0) begin
            r_short <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_sel_ok) begin
            r_coin  <= w_sel_coin;
`ifdef CHG_TIMEOUT_EN
            r_wait  <= '0;
`endif
            r_state <= ST_EJECT;
          end else begin
            r_short <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_EJECT: begin
          if (eject_ready) begin
            r_rem   <= r_rem - AMT_W'(coin_value(r_coin));
            r_state <= ST_SELECT;
          end
`ifdef CHG_TIMEOUT_EN
          else if (r_wait == WAIT_W'(TIMEOUT_CYC - 1)) begin
            r_jam   <= 1'b1;
            r_short <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Decoded from the state register so a reset drops eject_valid without waiting for a clock
  assign eject_valid = (r_state == ST_EJECT);
  assign eject_coin  = r_coin;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign short       = r_short;
  assign remaining   = r_rem;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed and randomized payouts checked against an inventory/greedy model
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] amount;
  logic       refill_en;
  logic [1:0] refill_coin;
  logic [5:0] refill_qty;
  logic       eject_ready;
  logic       eject_valid;
  logic [1:0] eject_coin;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] remaining;
`ifdef CHG_TIMEOUT_EN
  logic       jam;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt[3];

  change_dispenser #(
    .AMT_W       (8),
    .CNT_W       (6),
    .INIT_CNT    (10),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .amount      (amount),
    .refill_en   (refill_en),
    .refill_coin (refill_coin),
    .refill_qty  (refill_qty),
    .eject_ready (eject_ready),
    .eject_valid (eject_valid),
    .eject_coin  (eject_coin),
    .busy        (busy),
    .done        (done),
    .short       (short),
    .remaining   (remaining)
`ifdef CHG_TIMEOUT_EN
    ,
    .jam         (jam)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int coin_val(input int c);
    return (c == 2) ? 5 : (c == 1) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 10;
  endtask

  task automatic model_refill(input int coin, input int qty);
    if (coin < 3) m_cnt[coin] = (m_cnt[coin] + qty > 63) ? 63 : m_cnt[coin] + qty;
  endtask

  task automatic refill(input int coin, input int qty);
    @(negedge clk);
    refill_en   = 1'b1;
    refill_coin = 2'(coin);
    refill_qty  = 6'(qty);
    @(negedge clk);
    refill_en = 1'b0;
    model_refill(coin, qty);
  endtask

  // Full payout: expected coin list comes from the greedy rule applied to the model inventory
  task automatic pay(input int amt, input int hold0, input bit poke,
                     input bit rf_en, input int rf_coin, input int rf_qty, input bit rnd_hold);
    int coins[$];
    int rem;
    int run;
    int hold;
    int c;
    bit exp_short;
    if (rf_en) model_refill(rf_coin, rf_qty);
    rem = amt;
    exp_short = 1'b0;
    while (rem > 0) begin
      if (rem >= 5 && m_cnt[2] > 0) c = 2;
      else if (rem >= 2 && m_cnt[1] > 0) c = 1;
      else if (m_cnt[0] > 0) c = 0;
      else begin
        exp_short = 1'b1;
        break;
      end
      coins.push_back(c);
      m_cnt[c]--;
      rem -= coin_val(c);
    end

    @(negedge clk);
    start       = 1'b1;
    amount      = 8'(amt);
    refill_en   = rf_en;
    refill_coin = 2'(rf_coin);
    refill_qty  = 6'(rf_qty);
    @(negedge clk);
    start     = 1'b0;
    refill_en = 1'b0;
    check("busy_sel", busy, 1);
    check("valid_sel", eject_valid, 0);
    run = amt;
    foreach (coins[i]) begin
      hold = (i == 0) ? hold0 : (rnd_hold ? $urandom_range(0, 3) : 0);
      @(negedge clk);
      eject_ready = 1'b0;
      check("valid_ej", eject_valid, 1);
      check("coin", eject_coin, coins[i]);
      check("rem_ej", remaining, run);
      for (int k = 0; k < hold; k++) begin
        if (poke && k == 0) begin
          start       = 1'b1;
          amount      = 8'(amt + 1);
          refill_en   = 1'b1;
          refill_coin = 2'b00;
          refill_qty  = 6'd5;
        end
        @(negedge clk);
        start     = 1'b0;
        refill_en = 1'b0;
        check("valid_hold", eject_valid, 1);
        check("coin_hold", eject_coin, coins[i]);
      end
      eject_ready = 1'b1;
      @(negedge clk);
      eject_ready = 1'($urandom_range(0, 1));
      run -= coin_val(coins[i]);
      check("valid_gap", eject_valid, 0);
      check("rem_step", remaining, run);
    end
    @(negedge clk);
    eject_ready = 1'b0;
    check("done", done, 1);
    check("short", short, exp_short);
    check("rem_done", remaining, rem);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    amount      = '0;
    refill_en   = 1'b0;
    refill_coin = '0;
    refill_qty  = '0;
    eject_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_valid", eject_valid, 0);
    check("rst_coin", eject_coin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_short", short, 0);
    check("rst_rem", remaining, 0);
`ifdef CHG_TIMEOUT_EN
    check("rst_jam", jam, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    pay(8, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of an eject
    @(negedge clk);
    start  = 1'b1;
    amount = 8'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", eject_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", eject_valid, 0);
    check("async_busy", busy, 0);
    check("async_rem", remaining, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    pay(50, 0, 0, 0, 0, 0, 0);
    pay(5, 0, 0, 0, 0, 0, 0);
    pay(8, 7, 1, 0, 0, 0, 0);
    pay(17, 0, 0, 0, 0, 0, 1);
    pay(3, 0, 0, 0, 0, 0, 0);
    refill(3, 5);
    pay(1, 0, 0, 0, 0, 0, 0);
    pay(2, 0, 0, 1, 0, 2, 0);
    refill(1, 40);
    refill(1, 63);
    pay(127, 0, 0, 0, 0, 0, 0);

    for (int it = 0; it < 12; it++) begin
      refill($urandom_range(0, 3), $urandom_range(0, 63));
      pay($urandom_range(0, 60), $urandom_range(0, 2), 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 20), 1);
    end

`ifdef CHG_TIMEOUT_EN
    begin
      int nvalid;
      bit seen_done;
      refill(0, 1);
      @(negedge clk);
      start  = 1'b1;
      amount = 8'd1;
      @(negedge clk);
      start = 1'b0;
      nvalid = 0;
      seen_done = 1'b0;
      for (int k = 0; k < 40 && !seen_done; k++) begin
        @(negedge clk);
        if (eject_valid) nvalid++;
        if (done) seen_done = 1'b1;
      end
      check("to_done", seen_done, 1);
      check("to_cycles", nvalid, 16);
      check("to_jam", jam, 1);
      check("to_short", short, 1);
      check("to_rem", remaining, 1);
      pay(0, 0, 0, 0, 0, 0, 0);
      check("jam_clear", jam, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
